adder_tree_acc: RTL and testbench

// - Parametrised pipelined signed adder tree with a group accumulator and valid/last framing.
// - Reduces ARRAY_SIZE PE results per beat to one lossless sum.
// - Optionally accumulates successive beats into one K-tile result.
// - Sits between the PE array and the output buffer of the matmul datapath.
// - Supersedes the fixed 128-input, 7-level tree.

---
 rtl/adder_tree_acc.sv | 185 ++++++++++++++++++
 tb/tb_adder_tree_acc.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree with a K-tile group accumulator and valid/last framing.
// Latency: LEVELS+1 cycles from the group-closing input beat to out_valid.
// Backpressure: none; a beat is accepted every cycle and in_valid gaps are allowed anywhere.
//
// Reduces ARRAY_SIZE signed PE results per beat to one lossless SUM_W-bit sum. The lane
// count is zero-padded up to the next power of two. Successive beats are then summed into
// one ACC_WIDTH-bit group result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears the pipeline, accumulator and any partial group
//   PE_result  packed inputs, element i = PE_result[i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   PE_result carries a beat this cycle
//   in_last    beat closes the current group (ignored when acc_en = 0)
//   acc_en     1 = accumulate beats up to in_last, 0 = every beat is its own group
//   out_data   signed group result; holds the last closed value between pulses
//   out_valid  one-cycle pulse per closed group
//   out_ovf    pulses with out_valid when the group overflowed ACC_WIDTH
//
// Build option ADDER_TREE_SAT_EN: when defined, an overflowing group clamps to the signed
// ACC_WIDTH limits and stays clamped. When undefined, the accumulator wraps in two's complement.
// In both builds the overflow is reported on out_ovf.
module adder_tree_acc #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_SIZE = 128,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] PE_result,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic                           acc_en,
  output logic [ACC_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  output logic                           out_ovf
);

  localparam int LEVELS = $clog2(ARRAY_SIZE);
  localparam int LANES  = 1 << LEVELS;
  localparam int SUM_W  = DATA_WIDTH + LEVELS;
  localparam int PAD_W  = LANES * DATA_WIDTH;

`ifdef ADDER_TREE_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  // Zero-extending the packed input fills the padding lanes with 0.
  logic [PAD_W-1:0] pe_pad;
  assign pe_pad = PAD_W'(PE_result);

  // Level k holds LANES>>k nodes of width DATA_WIDTH+k. Level 0 is the unregistered input.
  // Every later level is a registered pairwise add of sign-extended operands.
  genvar k;
  generate
    for (k = 0; k <= LEVELS; k++) begin : g_lvl
      localparam int W = DATA_WIDTH + k;
      localparam int N = LANES >> k;
      logic signed [W-1:0] node [N];

      if (k == 0) begin : g_in
        always_comb begin
          for (int j = 0; j < N; j++) begin
            node[j] = pe_pad[j*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end else begin : g_add
        always_ff @(posedge clk) begin
          if (rst) begin
            for (int j = 0; j < N; j++) node[j] <= '0;
          end else begin
            for (int j = 0; j < N; j++) begin
              node[j] <= {g_lvl[k-1].node[2*j][W-2],   g_lvl[k-1].node[2*j]}
                       + {g_lvl[k-1].node[2*j+1][W-2], g_lvl[k-1].node[2*j+1]};
            end
          end
        end
      end
    end
  endgenerate

  // Framing bits travel down the tree one level per cycle, aligned with their data.
  logic [LEVELS-1:0] vld_sr_q, last_sr_q, en_sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q  <= '0;
      last_sr_q <= '0;
      en_sr_q   <= '0;
    end else begin
      vld_sr_q[0]  <= in_valid;
      last_sr_q[0] <= in_last;
      en_sr_q[0]   <= acc_en;
      for (int j = 1; j < LEVELS; j++) begin
        vld_sr_q[j]  <= vld_sr_q[j-1];
        last_sr_q[j] <= last_sr_q[j-1];
        en_sr_q[j]   <= en_sr_q[j-1];
      end
    end
  end

  logic signed [SUM_W-1:0]     tree_sum;
  logic signed [ACC_WIDTH-1:0] addend;
  logic                        tree_vld, tree_close;

  assign tree_sum   = g_lvl[LEVELS].node[0];
  assign addend     = ACC_WIDTH'(tree_sum);
  assign tree_vld   = vld_sr_q[LEVELS-1];
  // A beat with acc_en = 0 always closes, whatever its last bit says.
  assign tree_close = last_sr_q[LEVELS-1] | ~en_sr_q[LEVELS-1];

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic                        first_q, first_d, grp_ovf_q, grp_ovf_d;
  logic                        out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
  logic signed [ACC_WIDTH-1:0] sum_raw, acc_nxt;
  logic                        add_ovf, ovf_nxt;

  always_comb begin
    sum_raw = acc_q + addend;
    // Signed overflow: operands agree in sign and the wrapped result does not.
    add_ovf = (acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
              (sum_raw[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    acc_nxt = sum_raw;
    ovf_nxt = grp_ovf_q | add_ovf;
    if (first_q) begin
      // SUM_W <= ACC_WIDTH, so loading the first beat can never overflow.
      acc_nxt = addend;
      ovf_nxt = 1'b0;
    end else begin
`ifdef ADDER_TREE_SAT_EN
      // Once a group has clamped, later beats leave the clamp value untouched.
      if (grp_ovf_q) begin
        acc_nxt = acc_q;
      end else if (add_ovf) begin
        acc_nxt = acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
      end
`endif
    end

    acc_d       = acc_q;
    first_d     = first_q;
    grp_ovf_d   = grp_ovf_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_ovf_d   = 1'b0;
    if (tree_vld) begin
      acc_d = acc_nxt;
      if (tree_close) begin
        out_data_d  = acc_nxt;
        out_valid_d = 1'b1;
        out_ovf_d   = ovf_nxt;
        first_d     = 1'b1;
        grp_ovf_d   = 1'b0;
      end else begin
        first_d   = 1'b0;
        grp_ovf_d = ovf_nxt;
      end
    end
  end

  // The first-beat flag resets to its start-of-group state so no partial group survives reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      first_q     <= 1'b1;
      grp_ovf_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      grp_ovf_q   <= grp_ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Bench for adder_tree_acc: three instances share one stimulus stream.
//   u_a: 128 lanes, 32-bit accumulator
//   u_b: 128 lanes, 24-bit accumulator (overflow cases)
//   u_c: 100 lanes, 32-bit accumulator (padding)
// A cycle-indexed behavioural model predicts every output pulse.
// Directed tests pin the model with hand-computed values.
module tb_adder_tree_acc;

  localparam int DW   = 16;
  localparam int L    = 7;
  localparam int MAXC = 4096;

`ifdef ADDER_TREE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, in_last, acc_en;
  logic [15:0] lane [128];
  logic [DW*128-1:0] pe_full;
  logic [DW*100-1:0] pe_100;

  always_comb begin
    for (int i = 0; i < 128; i++) pe_full[i*DW +: DW] = lane[i];
    for (int i = 0; i < 100; i++) pe_100[i*DW +: DW] = lane[i];
  end

  logic [31:0] dat_a, dat_c;
  logic [23:0] dat_b;
  logic vld_a, vld_b, vld_c, ovf_a, ovf_b, ovf_c;

  adder_tree_acc u_a (
    .clk(clk), .rst(rst), .PE_result(pe_full), .in_valid(in_valid), .in_last(in_last),
    .acc_en(acc_en), .out_data(dat_a), .out_valid(vld_a), .out_ovf(ovf_a));
  adder_tree_acc #(.ACC_WIDTH(24)) u_b (
    .clk(clk), .rst(rst), .PE_result(pe_full), .in_valid(in_valid), .in_last(in_last),
    .acc_en(acc_en), .out_data(dat_b), .out_valid(vld_b), .out_ovf(ovf_b));
  adder_tree_acc #(.ARRAY_SIZE(100)) u_c (
    .clk(clk), .rst(rst), .PE_result(pe_100), .in_valid(in_valid), .in_last(in_last),
    .acc_en(acc_en), .out_data(dat_c), .out_valid(vld_c), .out_ovf(ovf_c));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     cyc = 0;
  bit     armed = 1'b0;
  bit     s_vld [3][MAXC];
  longint s_dat [3][MAXC];
  bit     s_ovf [3][MAXC];
  bit     m_first [3];
  bit     m_ovf [3];
  longint m_acc [3];
  longint held [3];
  bit     exp_vld [3];
  bit     exp_ovf [3];

  function automatic longint lane_sum(input int n);
    longint s = 0;
    for (int i = 0; i < n; i++) s += longint'($signed(lane[i]));
    return s;
  endfunction

  function automatic longint wrap(input longint a, input int w);
    longint m = longint'(1) << w;
    longint r = a & (m - 1);
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  initial begin
    int w;
    longint lo, hi, s, a;
    bit o;
    forever begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        w  = (d == 1) ? 24 : 32;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        if (rst) begin
          armed      = 1'b1;
          m_first[d] = 1'b1;
          m_acc[d]   = 0;
          m_ovf[d]   = 1'b0;
          held[d]    = 0;
          exp_vld[d] = 1'b0;
          exp_ovf[d] = 1'b0;
          for (int t = cyc; t <= cyc + L && t < MAXC; t++) s_vld[d][t] = 1'b0;
        end else begin
          exp_vld[d] = s_vld[d][cyc];
          exp_ovf[d] = s_ovf[d][cyc];
          if (s_vld[d][cyc]) held[d] = s_dat[d][cyc];
          if (in_valid) begin
            s = lane_sum(d == 2 ? 100 : 128);
            if (m_first[d]) begin
              a = s;
              o = 1'b0;
            end else begin
              o = m_ovf[d];
              if (SAT && m_ovf[d]) begin
                a = m_acc[d];
              end else begin
                a = m_acc[d] + s;
                if (a > hi || a < lo) begin
                  o = 1'b1;
                  a = SAT ? ((a > hi) ? hi : lo) : wrap(a, w);
                end
              end
            end
            if (in_last || !acc_en) begin
              if (cyc + L < MAXC) begin
                s_vld[d][cyc+L] = 1'b1;
                s_dat[d][cyc+L] = a;
                s_ovf[d][cyc+L] = o;
              end
              m_first[d] = 1'b1;
              m_ovf[d]   = 1'b0;
            end else begin
              m_first[d] = 1'b0;
              m_acc[d]   = a;
              m_ovf[d]   = o;
            end
          end
        end
      end
    end
  end

  // ---------------- compare + pulse log ----------------
  typedef struct { int cyc; longint dat; bit ovf; } pulse_t;
  pulse_t q0[$];
  pulse_t q1[$];
  pulse_t q2[$];

  initial begin
    pulse_t p;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        check("vld_a", longint'(vld_a), longint'(exp_vld[0]));
        check("vld_b", longint'(vld_b), longint'(exp_vld[1]));
        check("vld_c", longint'(vld_c), longint'(exp_vld[2]));
        check("dat_a", longint'($signed(dat_a)), held[0]);
        check("dat_b", longint'($signed(dat_b)), held[1]);
        check("dat_c", longint'($signed(dat_c)), held[2]);
        if (exp_vld[0]) check("ovf_a", longint'(ovf_a), longint'(exp_ovf[0]));
        if (exp_vld[1]) check("ovf_b", longint'(ovf_b), longint'(exp_ovf[1]));
        if (exp_vld[2]) check("ovf_c", longint'(ovf_c), longint'(exp_ovf[2]));
        if (vld_a) begin p.cyc = cyc; p.dat = longint'($signed(dat_a)); p.ovf = ovf_a; q0.push_back(p); end
        if (vld_b) begin p.cyc = cyc; p.dat = longint'($signed(dat_b)); p.ovf = ovf_b; q1.push_back(p); end
        if (vld_c) begin p.cyc = cyc; p.dat = longint'($signed(dat_c)); p.ovf = ovf_c; q2.push_back(p); end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 128; i++) lane[i] = v;
  endtask

  task automatic fill_idx();
    for (int i = 0; i < 128; i++) lane[i] = 16'(i);
  endtask

  task automatic beat(input bit last, input bit en);
    in_valid = 1'b1;
    in_last  = last;
    acc_en   = en;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  function automatic int log_size(input int d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  function automatic pulse_t log_get(input int d, input int idx);
    pulse_t p;
    p.cyc = -1; p.dat = 0; p.ovf = 1'b0;
    if (idx < log_size(d)) p = (d == 0) ? q0[idx] : (d == 1) ? q1[idx] : q2[idx];
    return p;
  endfunction

  task automatic chk_cnt(input int d, input string nm, input int n);
    check({nm, "_count"}, longint'(log_size(d)), longint'(n));
  endtask

  // Checks pulse idx of instance d against literal data/ovf and, if at >= 0, its cycle.
  task automatic chk_pulse(input int d, input int idx, input string nm,
                           input longint dat, input bit ovf, input int at);
    pulse_t p;
    p = log_get(d, idx);
    check({nm, "_dat"}, p.dat, dat);
    check({nm, "_ovf"}, longint'(p.ovf), longint'(ovf));
    if (at >= 0) check({nm, "_cyc"}, longint'(p.cyc), longint'(at));
  endtask

  initial begin
    int t0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; acc_en = 1'b0;
    fill(16'h0000);
    repeat (3) @(negedge clk);
    check("rst_dat_a", longint'(dat_a), 0);
    check("rst_vld_a", longint'(vld_a), 0);
    check("rst_ovf_a", longint'(ovf_a), 0);
    check("rst_dat_b", longint'(dat_b), 0);
    check("rst_vld_c", longint'(vld_c), 0);
    rst = 1'b0;
    gap(2);

    // 1: single beat of ones, own group
    clear_logs();
    fill(16'h0001); t0 = cyc; beat(1'b0, 1'b0); gap(12);
    chk_cnt(0, "t1_a", 1);
    chk_pulse(0, 0, "t1_a", 128, 1'b0, t0 + 8);
    chk_pulse(2, 0, "t1_c", 100, 1'b0, t0 + 8);

    // 2: +1 then -1 on consecutive beats
    clear_logs();
    fill(16'h0001); t0 = cyc; beat(1'b0, 1'b0);
    fill(16'hFFFF); beat(1'b0, 1'b0); gap(12);
    chk_cnt(0, "t2_a", 2);
    chk_pulse(0, 0, "t2_a0", 128, 1'b0, t0 + 8);
    chk_pulse(0, 1, "t2_a1", -128, 1'b0, t0 + 9);

    // 3: four-beat group with an idle cycle inside
    clear_logs();
    fill(16'h7FFF);
    beat(1'b0, 1'b1); beat(1'b0, 1'b1); gap(1); beat(1'b0, 1'b1);
    t0 = cyc; beat(1'b1, 1'b1); gap(12);
    chk_cnt(0, "t3_a", 1);
    chk_pulse(0, 0, "t3_a", 16776704, 1'b0, t0 + 8);
    chk_pulse(1, 0, "t3_b", SAT ? 8388607 : -512, 1'b1, t0 + 8);

    // 4: reset discards a partial group; a fresh group follows
    clear_logs();
    fill(16'h7FFF);
    beat(1'b0, 1'b1); beat(1'b0, 1'b1);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    gap(12);
    chk_cnt(0, "t4_a_none", 0);
    chk_cnt(1, "t4_b_none", 0);
    fill(16'h0001); t0 = cyc; beat(1'b1, 1'b1); gap(12);
    chk_cnt(0, "t4_a", 1);
    chk_pulse(0, 0, "t4_a", 128, 1'b0, t0 + 8);

    // 5: five beats of 0x7FFF overflow the 24-bit accumulator
    clear_logs();
    fill(16'h7FFF);
    repeat (4) beat(1'b0, 1'b1);
    t0 = cyc; beat(1'b1, 1'b1); gap(12);
    chk_pulse(1, 0, "t5_b", SAT ? 8388607 : 4193664, 1'b1, t0 + 8);
    chk_pulse(0, 0, "t5_a", 20970880, 1'b0, t0 + 8);

    // 6: lane i = i, padding lanes contribute 0
    clear_logs();
    fill_idx(); t0 = cyc; beat(1'b0, 1'b0); gap(12);
    chk_pulse(2, 0, "t6_c", 4950, 1'b0, t0 + 8);
    chk_pulse(0, 0, "t6_a", 8128, 1'b0, t0 + 8);

    // Negative boundary: exactly -2^23 fits the 24-bit accumulator, one more beat overflows
    clear_logs();
    fill(16'h8000);
    beat(1'b0, 1'b1); beat(1'b1, 1'b1);
    beat(1'b0, 1'b1); beat(1'b0, 1'b1); beat(1'b1, 1'b1); gap(12);
    chk_cnt(1, "neg_b", 2);
    chk_pulse(1, 0, "neg_b0", -8388608, 1'b0, -1);
    chk_pulse(1, 1, "neg_b1", SAT ? -8388608 : 4194304, 1'b1, -1);

    // acc_en dropping mid-group closes it; last on an acc_en=0 beat changes nothing
    clear_logs();
    fill(16'h0001);
    beat(1'b0, 1'b1); beat(1'b0, 1'b1); t0 = cyc; beat(1'b1, 1'b0); beat(1'b0, 1'b0); gap(12);
    chk_cnt(0, "tog_a", 2);
    chk_pulse(0, 0, "tog_a0", 384, 1'b0, t0 + 8);
    chk_pulse(0, 1, "tog_a1", 128, 1'b0, t0 + 9);

    // Back-to-back single-beat groups with mixed lane values, checked by the model
    clear_logs();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 128; i++) lane[i] = 16'((i * 257 + b * 4099) ^ 16'hA5A5);
      beat(1'b1, 1'b1);
    end
    gap(12);
    chk_cnt(0, "b2b_a", 6);

    gap(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
